// File: rtl/ct_ifu_tag_pkg.sv
// Shared definitions for the IFU tag SRAM access controller.
// Geometry of the 512x22 tag array, FSM state encoding, way-field type
// and the per-way write-enable mask helper.
package ct_ifu_tag_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int WAY_WIDTH  = 11;
  localparam int DATA_WIDTH = 2 * WAY_WIDTH;
  localparam int ENTRY_NUM  = 512;

  // FSM state; constants kept as plain localparams for legacy tools
  typedef logic [1:0] ct_ifu_tag_state_t;
  localparam ct_ifu_tag_state_t ST_INIT = 2'd0;
  localparam ct_ifu_tag_state_t ST_IDLE = 2'd1;
  localparam ct_ifu_tag_state_t ST_INV  = 2'd2;

  // One way field: valid bit plus tag
  typedef logic [WAY_WIDTH-1:0] ct_ifu_tag_way_t;

  // Active-low bit write enable: only the selected way's bits are driven low
  function automatic logic [DATA_WIDTH-1:0] way_wen(input logic way);
    logic [DATA_WIDTH-1:0] wen_v;
    if (way) begin
      wen_v = {{WAY_WIDTH{1'b0}}, {WAY_WIDTH{1'b1}}};
    end else begin
      wen_v = {{WAY_WIDTH{1'b1}}, {WAY_WIDTH{1'b0}}};
    end
    return wen_v;
  endfunction

endpackage

// File: rtl/ct_ifu_tag_inv_cnt.sv
// Sweep index counter for the invalidate / post-reset init sweep.
// Advances one entry per sweep cycle, flags the last entry, and wraps
// back to zero after the last entry is written.
module ct_ifu_tag_inv_cnt
  import ct_ifu_tag_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] cnt_r;

  // Sweep index: zero outside sweeps, +1 for every entry written
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if (clr) begin
      cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = (cnt_r == ADDR_WIDTH'(ENTRY_NUM - 1));

endmodule

// File: rtl/ct_ifu_tag_sram_ctrl.sv
// Access controller in front of the 512x22 IFU tag single-port SRAM.
// Arbitrates refill writes (highest), fetch tag reads, and an
// invalidate-all sweep (also run after reset) onto the single port.
// Read data returns one cycle after the grant, straight from SRAM Q.
// Optional macro CT_IFU_TAG_RD_FILTER_EN: repeat reads of the last
// SRAM-read index are served from a local copy without an SRAM access.
module ct_ifu_tag_sram_ctrl
  import ct_ifu_tag_pkg::*;
(
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  inv_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  input  logic                  refill_req,
  input  logic [ADDR_WIDTH-1:0] refill_idx,
  input  logic                  refill_way,
  input  logic [WAY_WIDTH-1:0]  refill_data,
  output logic                  refill_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  ct_ifu_tag_state_t     state_r;
  ct_ifu_tag_state_t     state_nxt_s;
  logic                  sweep_s;
  logic                  idle_s;
  logic [ADDR_WIDTH-1:0] cnt_s;
  logic                  cnt_last_s;
  logic                  refill_gnt_s;
  logic                  rd_gnt_s;
  logic                  rd_hit_s;
  logic                  acc_s;
  logic [ADDR_WIDTH-1:0] a_s;
  logic [DATA_WIDTH-1:0] d_s;
  logic                  gwen_s;
  logic [DATA_WIDTH-1:0] wen_s;
  logic [ADDR_WIDTH-1:0] a_hold_r;
  logic [DATA_WIDTH-1:0] d_hold_r;
  logic                  rd_vld_r;
  logic                  inv_done_r;

  assign sweep_s = (state_r == ST_INIT) || (state_r == ST_INV);
  assign idle_s  = (state_r == ST_IDLE);

  ct_ifu_tag_inv_cnt u_inv_cnt (
    .clk  (forever_cpuclk),
    .rst  (cpurst),
    .clr  (~sweep_s),
    .inc  (sweep_s),
    .cnt  (cnt_s),
    .last (cnt_last_s)
  );

  // Fixed priority: refill beats read; nothing is granted while sweeping
  assign refill_gnt_s = ~cpurst & idle_s & refill_req;
  assign rd_gnt_s     = ~cpurst & idle_s & rd_req & ~refill_req;

  // Next-state: sweeps end on the last entry, inv_req only acts in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT, ST_INV: begin
        if (cnt_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_IDLE: begin
        if (inv_req) begin
          state_nxt_s = ST_INV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State register; reset always restarts the init sweep
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // SRAM port decode; A/D fall back to the last driven values when idle
  always_comb begin
    acc_s  = 1'b0;
    a_s    = a_hold_r;
    d_s    = d_hold_r;
    gwen_s = 1'b1;
    wen_s  = {DATA_WIDTH{1'b1}};
    if (cpurst) begin
      acc_s = 1'b0;
    end else if (sweep_s) begin
      acc_s  = 1'b1;
      a_s    = cnt_s;
      d_s    = {DATA_WIDTH{1'b0}};
      gwen_s = 1'b0;
      wen_s  = {DATA_WIDTH{1'b0}};
    end else if (refill_gnt_s) begin
      acc_s  = 1'b1;
      a_s    = refill_idx;
      d_s    = {refill_data, refill_data};
      gwen_s = 1'b0;
      wen_s  = way_wen(refill_way);
    end else if (rd_gnt_s && !rd_hit_s) begin
      acc_s  = 1'b1;
      a_s    = rd_idx;
      gwen_s = 1'b1;
    end else begin
      acc_s = 1'b0;
    end
  end

  // Remember the last address/data driven so idle cycles do not toggle them
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      a_hold_r <= {ADDR_WIDTH{1'b0}};
      d_hold_r <= {DATA_WIDTH{1'b0}};
    end else if (acc_s) begin
      a_hold_r <= a_s;
      d_hold_r <= d_s;
    end else begin
      a_hold_r <= a_hold_r;
      d_hold_r <= d_hold_r;
    end
  end

  // Read-valid one cycle after grant; done pulse after the last sweep write
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rd_vld_r   <= 1'b0;
      inv_done_r <= 1'b0;
    end else begin
      rd_vld_r   <= rd_gnt_s;
      inv_done_r <= sweep_s & cnt_last_s;
    end
  end

`ifdef CT_IFU_TAG_RD_FILTER_EN
  logic [ADDR_WIDTH-1:0] rd_idx_r;
  logic                  rd_real_r;
  logic                  rd_ret_real_s;
  logic [ADDR_WIDTH-1:0] last_idx_r;
  logic [DATA_WIDTH-1:0] last_data_r;
  logic                  last_ok_r;

  assign rd_ret_real_s = rd_vld_r & rd_real_r & ~cpurst;

  // A real read returning this cycle supersedes the held copy, so match on it
  assign rd_hit_s = rd_gnt_s &
                    (rd_ret_real_s ? (rd_idx == rd_idx_r)
                                   : (last_ok_r & (rd_idx == last_idx_r)));

  // Track whether the outstanding read went to the SRAM, and its index
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rd_real_r <= 1'b0;
      rd_idx_r  <= {ADDR_WIDTH{1'b0}};
    end else if (rd_gnt_s) begin
      rd_real_r <= ~rd_hit_s;
      rd_idx_r  <= rd_idx;
    end else begin
      rd_real_r <= 1'b0;
      rd_idx_r  <= rd_idx_r;
    end
  end

  // Held copy: filled by real reads, killed by sweeps and same-index refills
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      last_ok_r   <= 1'b0;
      last_idx_r  <= {ADDR_WIDTH{1'b0}};
      last_data_r <= {DATA_WIDTH{1'b0}};
    end else if (sweep_s) begin
      last_ok_r   <= 1'b0;
      last_idx_r  <= last_idx_r;
      last_data_r <= last_data_r;
    end else if (rd_ret_real_s) begin
      last_ok_r   <= ~(refill_gnt_s & (refill_idx == rd_idx_r));
      last_idx_r  <= rd_idx_r;
      last_data_r <= sram_q;
    end else if (refill_gnt_s && (refill_idx == last_idx_r)) begin
      last_ok_r   <= 1'b0;
      last_idx_r  <= last_idx_r;
      last_data_r <= last_data_r;
    end else begin
      last_ok_r   <= last_ok_r;
      last_idx_r  <= last_idx_r;
      last_data_r <= last_data_r;
    end
  end

  assign rd_data = rd_real_r ? sram_q : last_data_r;
`else
  assign rd_hit_s = 1'b0;
  assign rd_data  = sram_q;
`endif

  assign inv_busy   = cpurst | sweep_s;
  assign inv_done   = inv_done_r & ~cpurst;
  assign refill_gnt = refill_gnt_s;
  assign rd_gnt     = rd_gnt_s;
  assign rd_vld     = rd_vld_r & ~cpurst;
  assign sram_a     = a_s;
  assign sram_cen   = ~acc_s;
  assign sram_gwen  = gwen_s;
  assign sram_wen   = wen_s;
  assign sram_d     = d_s;

endmodule

// File: tb/tb_ct_ifu_tag_sram_ctrl.sv
// Bench for ct_ifu_tag_sram_ctrl: behavioural SRAM on the port, a plain
// array reference of tag contents, and a read-data scoreboard queue.
module tb_ct_ifu_tag_sram_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        inv_req;
  logic        inv_busy;
  logic        inv_done;
  logic        refill_req;
  logic [8:0]  refill_idx;
  logic        refill_way;
  logic [10:0] refill_data;
  logic        refill_gnt;
  logic        rd_req;
  logic [8:0]  rd_idx;
  logic        rd_gnt;
  logic        rd_vld;
  logic [21:0] rd_data;
  logic [8:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [21:0] sram_wen;
  logic [21:0] sram_d;
  logic [21:0] sram_q;

  ct_ifu_tag_sram_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .inv_req        (inv_req),
    .inv_busy       (inv_busy),
    .inv_done       (inv_done),
    .refill_req     (refill_req),
    .refill_idx     (refill_idx),
    .refill_way     (refill_way),
    .refill_data    (refill_data),
    .refill_gnt     (refill_gnt),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_gnt         (rd_gnt),
    .rd_vld         (rd_vld),
    .rd_data        (rd_data),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with bit write enables
  logic [21:0] sram_mem [512];
  logic [21:0] q_r;
  assign sram_q = q_r;
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else q_r <= sram_mem[sram_a];
    end
  end

  // Reference state
  logic [21:0] model_mem [512];
  logic [21:0] exp_q [$];
  bit          f_ok;
  logic [8:0]  f_idx;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          sweep_cnt = 0;
  int          done_cnt  = 0;
  int          exp_done  = 0;
  bit          prev_gnt  = 1'b0;
  logic [8:0]  pool [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) model_mem[i] = 22'h0;
    f_ok = 1'b0;
  endtask

  // Monitor: reset outputs, read latency/data scoreboard, sweep writes
  always @(negedge clk) begin
    logic [21:0] e;
    logic [8:0]  sa;
    if (cpurst) begin
      check("reset_outputs", {inv_busy, inv_done, rd_vld, refill_gnt, rd_gnt, sram_cen, sram_gwen, sram_wen},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 22'h3FFFFF});
      exp_q.delete();
      prev_gnt  = 1'b0;
      sweep_cnt = 0;
    end else begin
      check("rd_vld_latency", rd_vld, prev_gnt);
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          check("rd_vld_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e);
        end
      end
      prev_gnt = rd_gnt;
      if (inv_busy) begin
        sa = sweep_cnt[8:0];
        check("sweep_write", {sram_cen, sram_gwen, sram_wen, sram_d, sram_a},
              {1'b0, 1'b0, 22'h0, 22'h0, sa});
        check("busy_no_gnt", {refill_gnt, rd_gnt}, 2'b00);
        sweep_cnt++;
      end
      if (inv_done) begin
        check("sweep_len", sweep_cnt, 512);
        sweep_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (inv_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", inv_busy, 1'b0);
    @(posedge clk); #2;
  endtask

  // Raise refill and/or read together; each is dropped once granted
  task automatic issue(input bit do_ref, input logic [8:0] fidx, input bit fway,
                       input logic [10:0] fdata, input bit do_rd, input logic [8:0] ridx);
    bit rp, dp;
    logic [21:0] ewen;
    rp = do_ref; dp = do_rd;
    refill_req = rp; refill_idx = fidx; refill_way = fway; refill_data = fdata;
    rd_req = dp; rd_idx = ridx;
    while (rp || dp) begin
      @(negedge clk);
      if (rp) begin
        check("refill_gnt", {refill_gnt, rd_gnt}, 2'b10);
        ewen = fway ? {11'h000, 11'h7FF} : {11'h7FF, 11'h000};
        check("refill_sram", {sram_cen, sram_gwen, sram_wen, sram_d, sram_a},
              {1'b0, 1'b0, ewen, fdata, fdata, fidx});
        if (fway) model_mem[fidx][21:11] = fdata;
        else      model_mem[fidx][10:0]  = fdata;
        if (fidx == f_idx) f_ok = 1'b0;
        rp = 1'b0;
      end else begin
        check("rd_gnt", {refill_gnt, rd_gnt}, 2'b01);
`ifdef CT_IFU_TAG_RD_FILTER_EN
        if (f_ok && f_idx == ridx) begin
          check("rd_filtered_cen", sram_cen, 1'b1);
        end else begin
          check("rd_sram", {sram_cen, sram_gwen, sram_a}, {1'b0, 1'b1, ridx});
          f_ok = 1'b1;
          f_idx = ridx;
        end
`else
        check("rd_sram", {sram_cen, sram_gwen, sram_a}, {1'b0, 1'b1, ridx});
`endif
        exp_q.push_back(model_mem[ridx]);
        dp = 1'b0;
      end
      @(posedge clk); #2;
      refill_req = rp; rd_req = dp;
    end
  endtask

  task automatic do_sweep(input bit mid_req);
    inv_req = 1'b1;
    @(posedge clk); #2;
    inv_req = 1'b0;
    if (mid_req) begin
      repeat (100) @(posedge clk);
      #2 inv_req = 1'b1;
      @(posedge clk); #2;
      inv_req = 1'b0;
    end
    wait_idle(700);
    model_clear();
    exp_done++;
  endtask

  initial begin
    int r;
    cpurst = 1'b1; inv_req = 1'b0; refill_req = 1'b0; refill_idx = 9'h0;
    refill_way = 1'b0; refill_data = 11'h0; rd_req = 1'b1; rd_idx = 9'h033;
    q_r = 22'h0;
    for (int i = 0; i < 512; i++) sram_mem[i] = 22'($urandom);
    model_clear();
    f_idx = 9'h0;
    pool[0] = 9'h05A; pool[1] = 9'h100;
    for (int i = 2; i < 8; i++) pool[i] = 9'($urandom);

    // Reset and init sweep with a read held pending throughout
    repeat (3) @(posedge clk);
    #2 cpurst = 1'b0;
    repeat (500) @(posedge clk);
    #2 rd_req = 1'b0;
    wait_idle(100);
    exp_done++;

    // Directed: way-1 refill then read of the same entry
    issue(1'b1, 9'h05A, 1'b1, 11'h3FF, 1'b0, 9'h0);
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h05A);
    // Simultaneous refill and read
    issue(1'b1, 9'h0A5, 1'b0, 11'h155, 1'b1, 9'h0A5);

    // Invalidate with a second request mid-sweep, then reads return zero
    do_sweep(1'b1);
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h05A);
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h0A5);

`ifdef CT_IFU_TAG_RD_FILTER_EN
    issue(1'b1, 9'h100, 1'b0, 11'h2AB, 1'b0, 9'h0);
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h100);
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h100);
    issue(1'b1, 9'h100, 1'b1, 11'h1CD, 1'b0, 9'h0);
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h100);
`endif

    // Reset while a read is outstanding: its rd_vld must vanish
    issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, 9'h05A);
    cpurst = 1'b1;
    repeat (2) @(posedge clk);
    #2 cpurst = 1'b0;
    model_clear();
    wait_idle(700);
    exp_done++;

    // Reset around sweep count 200: sweep restarts from entry 0
    inv_req = 1'b1;
    @(posedge clk); #2;
    inv_req = 1'b0;
    repeat (200) @(posedge clk);
    #2 cpurst = 1'b1;
    @(posedge clk); #2;
    cpurst = 1'b0;
    model_clear();
    wait_idle(700);
    exp_done++;

    // Randomized traffic over a small index pool
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)       do_sweep(i[0]);
      else if (r < 7)   issue(1'b1, pool[$urandom_range(0, 7)], 1'($urandom), 11'($urandom), 1'b0, 9'h0);
      else if (r < 15)  issue(1'b0, 9'h0, 1'b0, 11'h0, 1'b1, pool[$urandom_range(0, 7)]);
      else              issue(1'b1, pool[$urandom_range(0, 7)], 1'($urandom), 11'($urandom),
                              1'b1, pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #2;
      end
    end

    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_ifu_tag_sram_ctrl.md
Name: ct_ifu_tag_sram_ctrl

Overview:
Access controller that sits directly upstream of the 512x22 IFU tag single-port SRAM. It arbitrates fetch tag reads, refill tag writes and a full-array invalidate sweep onto the SRAM's single port. It drives A/CEN/GWEN/WEN/D and returns the SRAM's Q to the fetch pipeline one cycle after grant. Each 22-bit entry holds two 11-bit way fields: way1 in [21:11] and way0 in [10:0].

Parameters:
ADDR_WIDTH, 9, SRAM index width (512 entries)
WAY_WIDTH, 11, per-way field width (valid plus tag)
DATA_WIDTH, 22, 2*WAY_WIDTH; SRAM word width

Ports:
forever_cpuclk  in  1  single clock for the block and the SRAM
cpurst  in  1  reset, synchronous, active-high
inv_req  in  1  one-cycle pulse that starts an invalidate-all sweep
inv_busy  out  1  sweep in progress (includes post-reset init)
inv_done  out  1  one-cycle pulse after the last entry is written
refill_req  in  1  refill write request
refill_idx  in  ADDR_WIDTH  refill index
refill_way  in  1  0 = write [10:0], 1 = write [21:11]
refill_data  in  WAY_WIDTH  way field to write
refill_gnt  out  1  refill accepted this cycle
rd_req  in  1  fetch tag read request
rd_idx  in  ADDR_WIDTH  read index
rd_gnt  out  1  read accepted this cycle
rd_vld  out  1  read data valid
rd_data  out  DATA_WIDTH  both way fields
sram_a  out  ADDR_WIDTH  to SRAM A
sram_cen  out  1  to SRAM CEN, active-low
sram_gwen  out  1  to SRAM GWEN, active-low write
sram_wen  out  DATA_WIDTH  to SRAM WEN, per-bit active-low
sram_d  out  DATA_WIDTH  to SRAM D
sram_q  in  DATA_WIDTH  from SRAM Q, valid the cycle after a read access

Behaviour:
- Reset values: FSM = INIT, counter = 0, inv_busy = 1, inv_done = 0, rd_vld = 0, all grants = 0, sram_cen = 1, sram_gwen = 1, sram_wen = all ones.
- FSM has three states.
  - INIT/INV: every cycle write zero to entry cnt (CEN = 0, GWEN = 0, WEN = 0, D = 0), then cnt++. When cnt = 511: write it, pulse inv_done next cycle, go to IDLE, reset cnt to 0.
  - IDLE: serve requests by fixed priority, refill over read.
  - inv_req in IDLE goes to INV on the next cycle. The cycle in which inv_req is sampled still serves requests normally.
- In INIT/INV, inv_req is ignored: no restart, no second done pulse. refill_gnt = rd_gnt = 0.
- Refill grant drives an SRAM write of idx with D = {refill_data, refill_data}. WEN is low only on the selected way's 11 bits; the other way is preserved.
- Read grant drives an SRAM read (CEN = 0, GWEN = 1). rd_vld = 1 exactly one cycle after rd_gnt, with rd_data = sram_q combinationally. rd_data is don't-care when rd_vld = 0.
- Simultaneous refill and read: refill is granted, rd_gnt = 0, and the requester holds rd_req. Requests are level; the requester drops a request after seeing its grant.
- No access: CEN = 1, and A/D are held at their last values.
- Reset asserted mid-sweep or mid-read: sweep restarts from 0 and a pending rd_vld is dropped.

Optional Feature:
CT_IFU_TAG_RD_FILTER_EN
- Defined: keep last_idx, last_data and a last_ok flag. A read granted with rd_idx = last_idx and last_ok = 1 does not access the SRAM (CEN = 1). It still gives rd_vld the next cycle, with rd_data = last_data.
- last_ok is cleared by any refill to last_idx, by any sweep, and by reset. It is set when a real SRAM read returns, and last_data captures sram_q at the same time.
- Not defined: every granted read accesses the SRAM and no filter registers exist.

Decomposition:
- Package ct_ifu_tag_pkg holds:
  - typedef for the FSM state (INIT, IDLE, INV);
  - localparams ADDR_WIDTH, WAY_WIDTH, DATA_WIDTH and ENTRY_NUM = 512;
  - typedef for a way field (WAY_WIDTH bits).
- One natural sub-module, ct_ifu_tag_inv_cnt: the 9-bit sweep counter with a last-entry flag.

Test Plan:
- Reset release: inv_busy stays 1 for 512 cycles, each cycle writes entries 0 to 511 with D = 0 and WEN = 0. inv_done pulses once and inv_busy then drops. rd_req held during this window gets no grant.
- Refill idx 0x05A, way 1, data 0x3FF, then read 0x05A: sram_wen = {11'h0, 11'h7FF} on the write. rd_vld is seen 1 cycle after rd_gnt with rd_data[21:11] = 0x3FF and rd_data[10:0] unchanged.
- Refill and read requested in the same cycle: refill_gnt = 1, rd_gnt = 0. The next cycle gives rd_gnt = 1, and rd_vld follows one cycle later.
- inv_req pulsed in IDLE, then again mid-sweep: exactly 512 write cycles and a single inv_done. The following read of any index returns 0.
- Reset asserted at sweep count 200: the sweep restarts at 0 and completes 512 writes.
- With CT_IFU_TAG_RD_FILTER_EN: two reads of 0x100 back to back give CEN = 0 only on the first and identical rd_data on both. After a refill to 0x100 in between, the third read accesses the SRAM again.
